ocm_port_arbiter: RTL
=====================

OCM_PORT_ARBITER -- requirements
Module: ocm_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, the memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, the memory data width.
REQ-003 SHALL have parameter DEPTH, default 19200, the number of valid memory words.
REQ-004 SHALL have parameter MAX_WAIT, default 8, the maximum cycles requester B waits before it is forced priority (range 1..255).
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 a_req  in  1  requester A (video scan, read-only) access request.
REQ-008 a_addr  in  ADDR_W  requester A word address.
REQ-009 a_gnt  out  1  A request accepted this cycle.
REQ-010 a_rvalid  out  1  A read data valid.
REQ-011 a_rdata  out  DATA_W  A read data.
REQ-012 b_req  in  1  requester B (host) access request.
REQ-013 b_write  in  1  B access type: 1 = write, 0 = read.
REQ-014 b_addr  in  ADDR_W  requester B word address.
REQ-015 b_wdata  in  DATA_W  requester B write data.
REQ-016 b_gnt  out  1  B request accepted this cycle.
REQ-017 b_rvalid  out  1  B read data valid.
REQ-018 b_rdata  out  DATA_W  B read data.
REQ-019 oob_err  out  1  one-cycle pulse when a granted address is >= DEPTH.
REQ-020 mem_address  out  ADDR_W  to RAM address.
REQ-021 mem_chipselect  out  1  to RAM chipselect.
REQ-022 mem_write  out  1  to RAM write.
REQ-023 mem_writedata  out  DATA_W  to RAM writedata.
REQ-024 mem_clken  out  1  to RAM clken; tied high outside reset.
REQ-025 mem_readdata  in  DATA_W  from RAM; valid the cycle after the address cycle.

Function
REQ-026 SHALL grant at most one requester per cycle; a_gnt and b_gnt SHALL be combinational from the requests and the registered priority state, and SHALL allow back-to-back grants every cycle.
REQ-027 SHALL implement a priority FSM with two states: PRI_A (reset state), where A wins on simultaneous requests, and PRI_B, where B wins.
REQ-028 SHALL run an 8-bit wait counter: increment each cycle b_req=1 and b_gnt=0; clear on b_gnt or b_req=0; saturate at MAX_WAIT.
REQ-029 SHALL transition PRI_A->PRI_B when the counter reaches MAX_WAIT, and PRI_B->PRI_A on the cycle B is granted.
REQ-030 In PRI_B with b_req=0, SHALL grant A normally.
REQ-031 In a grant cycle, SHALL drive mem_address, mem_chipselect=1, mem_write and mem_writedata from the granted requester; mem_write SHALL be 0 for A.
REQ-032 With no grant, SHALL drive mem_chipselect=0 and mem_write=0.
REQ-033 On a granted read issued at cycle T, SHALL register mem_readdata at the end of T+1 and assert the owner's rvalid with rdata for exactly cycle T+2 (fixed latency 2).
REQ-034 SHALL track owner and read flag through a 2-stage pipeline so that interleaved A and B reads return in issue order with correct routing.
REQ-035 SHALL produce no rvalid for a granted write.
REQ-036 On a granted address >= DEPTH: SHALL force mem_chipselect=0 and mem_write=0, still assert gnt, pulse oob_err in cycle T, and for a read return rdata=0 with rvalid at T+2.
REQ-037 SHALL hold a_rdata and b_rdata at their last value while the corresponding rvalid is 0.

Reset
REQ-038 While reset_n=0, SHALL drive all outputs to 0, including mem_clken.
REQ-039 While reset_n=0, SHALL put the FSM in PRI_A, clear the wait counter, and clear both pipeline stages.
REQ-040 Reads in flight when reset asserts SHALL be discarded; no rvalid SHALL follow reset release.
REQ-041 The first grant SHALL be possible in the first clk edge cycle after reset_n deasserts.

Verification
REQ-042 Scenario: A reads 0x0010 alone, RAM[0x0010]=0x5A -> a_gnt at T, a_rvalid=1 and a_rdata=0x5A at T+2.
REQ-043 Scenario: B writes 0x12C0=0x33, then B reads 0x12C0 -> mem_write=1 for one cycle, no b_rvalid for the write, read returns 0x33 two cycles after its grant.
REQ-044 Scenario: a_req held high continuously, b_req high from cycle 0, MAX_WAIT=8 -> b_gnt in cycle 8, a_gnt in all other cycles, pattern repeats every 9 cycles.
REQ-045 Scenario: alternating grants A@0x0001, B@0x0002, A@0x0003 -> rvalids in order A, B, A with matching data and no cross-routing.
REQ-046 Scenario: B reads 0x4B00 (19200) -> oob_err pulse, mem_chipselect=0, b_rvalid with b_rdata=0x00 at T+2.
REQ-047 Scenario: reset_n pulsed low at T+1 after an A read grant -> no a_rvalid, FSM in PRI_A and all outputs 0 after release.

Source files
------------

// File: rtl/ocm_port_arbiter.sv
// Two-requester arbiter in front of a single-port on-chip RAM.
// Requester A (video scan, read-only) normally wins. Requester B (host,
// read/write) is promoted after waiting MAX_WAIT cycles. Reads return
// with a fixed latency of two cycles, routed to whichever requester
// issued them, in issue order.
module ocm_port_arbiter #(
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 19200,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_write,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              oob_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

   localparam logic [7:0]  MAX_WAIT_L = 8'(MAX_WAIT);
   localparam logic [31:0] DEPTH_L    = 32'(DEPTH);

   pri_t              pri_reg, pri_next;
   logic [7:0]        wait_reg, wait_next;
   logic              a_win, b_win, gnt_any, oob, rd_issue;
   logic [ADDR_W-1:0] sel_addr;

   // Stage 1 tracks a read while the RAM produces data; stage 2 is the
   // registered rvalid/rdata presented to the owner.
   logic              s1_valid_reg, s1_owner_reg, s1_oob_reg;
   logic              a_rvalid_reg, b_rvalid_reg;
   logic [DATA_W-1:0] a_rdata_reg, b_rdata_reg;

   // Combinational grant from the requests and the registered priority;
   // gated by reset so every output is quiet while reset_n is low.
   always_comb begin
      a_win = 1'b0;
      b_win = 1'b0;
      if (reset_n) begin
         if (pri_reg == PRI_B) begin
            b_win = b_req;
            a_win = a_req & ~b_req;
         end else begin
            a_win = a_req;
            b_win = b_req & ~a_req;
         end
      end
   end

   assign gnt_any  = a_win | b_win;
   assign sel_addr = b_win ? b_addr : a_addr;
   assign oob      = gnt_any && (32'(sel_addr) >= DEPTH_L);
   assign rd_issue = a_win | (b_win & ~b_write);

   // Out-of-range accesses still get a grant but never reach the RAM.
   assign mem_address    = gnt_any ? sel_addr : '0;
   assign mem_chipselect = gnt_any & ~oob;
   assign mem_write      = b_win & b_write & ~oob;
   assign mem_writedata  = (b_win & b_write) ? b_wdata : '0;
   assign mem_clken      = reset_n;
   assign oob_err        = oob;

   assign a_gnt    = a_win;
   assign b_gnt    = b_win;
   assign a_rvalid = a_rvalid_reg;
   assign b_rvalid = b_rvalid_reg;
   assign a_rdata  = a_rdata_reg;
   assign b_rdata  = b_rdata_reg;

   // Wait counter and priority next-state. Promotion happens on the edge
   // where the counter reaches MAX_WAIT so B wins in the very next cycle.
   always_comb begin
      wait_next = '0;
      if (b_req && !b_win)
         wait_next = (wait_reg >= MAX_WAIT_L) ? MAX_WAIT_L : wait_reg + 8'd1;
      pri_next = pri_reg;
      if (pri_reg == PRI_A && wait_next == MAX_WAIT_L)
         pri_next = PRI_B;
      else if (pri_reg == PRI_B && b_win)
         pri_next = PRI_A;
   end

   // Priority FSM and wait counter state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pri_reg  <= PRI_A;
         wait_reg <= '0;
      end else begin
         pri_reg  <= pri_next;
         wait_reg <= wait_next;
      end
   end

   // Read-return pipeline: owner/oob travel alongside the RAM latency,
   // rdata registers only update for their own owner so they hold otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_reg <= 1'b0;
         s1_owner_reg <= 1'b0;
         s1_oob_reg   <= 1'b0;
         a_rvalid_reg <= 1'b0;
         b_rvalid_reg <= 1'b0;
         a_rdata_reg  <= '0;
         b_rdata_reg  <= '0;
      end else begin
         s1_valid_reg <= rd_issue;
         s1_owner_reg <= b_win;
         s1_oob_reg   <= oob;
         a_rvalid_reg <= s1_valid_reg & ~s1_owner_reg;
         b_rvalid_reg <= s1_valid_reg &  s1_owner_reg;
         if (s1_valid_reg && !s1_owner_reg)
            a_rdata_reg <= s1_oob_reg ? '0 : mem_readdata;
         if (s1_valid_reg && s1_owner_reg)
            b_rdata_reg <= s1_oob_reg ? '0 : mem_readdata;
      end
   end

endmodule
